dma_reader: RTL and testbench
=============================

Name: dma_reader

Overview:
- Memory-to-stream DMA engine.
- On a start command it issues sequential reads of `length` words beginning at `base_addr` to a fixed-latency memory read port.
- It returns the read data in address order on a valid/ready output stream. A 2-entry internal buffer absorbs backpressure.
- It sits between the accelerator's data memory and the downstream compute/IO consumer, and is the read-side counterpart of the team's write DMA.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, memory address width.
- LEN_W, 16, transfer length counter width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first read address; captured on accepted start.
- length  in  LEN_W  number of words; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse on transfer completion.
- mem_rd_en  out  1  memory read request.
- mem_addr  out  ADDR_W  read address, valid when mem_rd_en=1.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en=1.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  DATA_W  stream word, equal to the buffer head.

Behaviour:
- Reset (rst=0, asynchronous) takes effect immediately:
  - busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0.
  - Buffer is emptied, counters are cleared, FSM goes to IDLE.
  - Any in-flight read data is discarded.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 with length!=0: latch base_addr and length, clear counters, go to RUN. busy=1 next cycle.
  - start=1 with length=0: go to FINISH. No memory read is issued; done pulses the next cycle.
- RUN, read issue:
  - mem_rd_en=1 when issued<length and (count + inflight - pop) < 2, where:
    - count = buffer occupancy (0..2).
    - inflight = mem_rd_en of the previous cycle.
    - pop = out_valid & out_ready.
  - mem_rd_en and mem_addr are combinational from registered state.
  - mem_addr = base + issued, modulo 2^ADDR_W. Wrap from all-ones to 0 is silent.
- RUN, data return:
  - In the cycle after a request, mem_rdata is written into the buffer tail at the clock edge.
  - Push and pop in the same cycle are both honoured.
  - The buffer never overflows by construction; overflow is a design error and is checked by assertion.
- Output stream:
  - out_valid = (count>0).
  - out_data is stable while out_valid=1 and out_ready=0.
  - Words are delivered strictly in issue order, with no duplicates and no drops.
- RUN to FINISH: on the edge where the length-th word is popped.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- Latency and throughput:
  - Start accepted at edge 0: first mem_rd_en in cycle 1, first out_valid in cycle 3.
  - With out_ready held high, sustained throughput is 1 word/cycle.
- Busy handling: start while busy=1 or in FINISH is ignored; the running transfer is unaffected.
- Widths:
  - length up to 2^LEN_W-1.
  - The issued and popped counters are LEN_W bits and are compared to the latched length.
- Reset mid-transfer: everything returns to reset values and no done pulse is produced. A new start after rst=1 behaves as a fresh transfer.

Test Plan:
- Basic transfer, out_ready=1: base=0x0010, length=4, memory model returns data=addr^0xA5A5.
  - mem_addr 0x0010..0x0013 in cycles 1-4.
  - out_data 0xA5B5,0xA5B4,0xA5B7,0xA5B6 in cycles 3-6.
  - done pulse in cycle 7.
- Backpressure: length=6, out_ready toggles 1,0,0,1,...
  - All 6 words delivered in order.
  - out_data stable during stalls.
  - count+inflight never exceeds 2; mem_rd_en drops while the buffer is full.
- Zero length: start with length=0 -> no mem_rd_en ever, out_valid stays 0, done=1 exactly one cycle after start.
- Address wrap: base=0xFFFE, length=4 -> mem_addr sequence 0xFFFE,0xFFFF,0x0000,0x0001; data delivered in that order.
- Start while busy: second start (base=0x0100, length=2) during a length=5 transfer.
  - Ignored; only 5 words from the original base are delivered.
  - Single done pulse.
- Reset mid-operation: assert rst=0 after 2 of 8 words have been popped.
  - All outputs go to 0 immediately; no done pulse.
  - After release, start base=0x0020, length=1 -> one word read from 0x0020, then done.

Source files
------------

// File: rtl/dma_reader.sv
// Memory-to-stream read DMA: sequential fixed-latency reads
// returned in order on a valid/ready stream via a 2-entry buffer.
module dma_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] ONE = 1;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  popped;
  logic              inflight;
  logic [DATA_W-1:0] fifo [2];
  logic              wptr;
  logic              rptr;
  logic [1:0]        count;

  logic       push;
  logic       pop;
  logic       last_pop;
  logic       accept;
  logic [2:0] occ;
  logic       room;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo[rptr];
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign accept    = (state == IDLE) && start;
  assign last_pop  = pop && ((popped + ONE) == len);

  // Words in the buffer plus one still coming back from memory.
  assign occ  = {1'b0, count} + {2'b00, inflight};
  assign room = occ < ({2'b00, pop} + 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (last_pop) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == FINISH);
    mem_rd_en = (state == RUN) && (issued < len) && room;
    mem_addr  = '0;
    if (mem_rd_en) begin
      mem_addr = base + ADDR_W'(issued);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base     <= '0;
      len      <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      inflight <= mem_rd_en;
      if (accept) begin
        base   <= base_addr;
        len    <= length;
        issued <= '0;
        popped <= '0;
      end else begin
        if (mem_rd_en) issued <= issued + ONE;
        if (pop)       popped <= popped + ONE;
      end
      if (push) begin
        fifo[wptr] <= mem_rdata;
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && !pop && count == 2'd2)
  );

endmodule

// File: tb/tb_dma_reader.sv
// Scoreboard bench for dma_reader: expected words queued at start,
// compared in order by a stream monitor; per-scenario timing checks.
module tb_dma_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int passes = 0;

  logic [15:0] expq [$];
  logic [15:0] mon_exp;
  int          outstanding = 0;
  int          pops = 0;
  bit          stall = 0;
  logic [15:0] stall_data;

  dma_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency memory: data = addr ^ 0xA5A5.
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
  end

  always @(negedge clk) begin
    if (!rst) begin
      outstanding = 0;
      stall = 0;
    end else begin
      checks++;
      if (outstanding + int'(mem_rd_en)
          - int'(out_valid & out_ready) > 2)
        $display("FAIL occupancy: got %0d, need <= 2",
          outstanding + int'(mem_rd_en)
          - int'(out_valid & out_ready));
      else passes++;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== stall_data)
          $display("FAIL stall_stable: got v=%b d=%h, need v=1 d=%h",
            out_valid, out_data, stall_data);
        else passes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (expq.size() == 0) begin
          $display("FAIL stream_extra: got %h, need no word", out_data);
        end else begin
          mon_exp = expq.pop_front();
          if (out_data !== mon_exp)
            $display("FAIL stream_data: got %h, need %h",
              out_data, mon_exp);
          else passes++;
        end
      end
      outstanding += int'(mem_rd_en) - int'(out_valid & out_ready);
      stall = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic start_xfer(input logic [15:0] b,
                            input logic [15:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    length = l;
    for (int i = 0; i < int'(l); i++) begin
      expq.push_back(16'(b + 16'(i)) ^ 16'hA5A5);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b1;
    #3;
    checks++;
    if ({busy, done, mem_rd_en, out_valid} !== 4'b0 ||
        mem_addr !== 16'h0 || out_data !== 16'h0)
      $display("FAIL reset_outputs: got b%b d%b r%b v%b a%h o%h, need 0",
        busy, done, mem_rd_en, out_valid, mem_addr, out_data);
    else passes++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, out_valid} !== 4'b0)
      $display("FAIL post_reset_idle: got %b, need 0000",
        {busy, done, mem_rd_en, out_valid});
    else passes++;
  endtask

  task automatic test_basic;
    logic er, ev, ed, eb;
    logic [15:0] ea;
    out_ready = 1'b1;
    start_xfer(16'h0010, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      er = (c <= 4);
      ev = (c >= 3 && c <= 6);
      ed = (c == 7);
      eb = (c <= 6);
      ea = 16'(16'h0010 + c - 1);
      checks++;
      if (mem_rd_en !== er || (er && mem_addr !== ea))
        $display("FAIL basic_rd c%0d: got %b/%h, need %b/%h",
          c, mem_rd_en, mem_addr, er, ea);
      else passes++;
      checks++;
      if (out_valid !== ev)
        $display("FAIL basic_valid c%0d: got %b, need %b",
          c, out_valid, ev);
      else passes++;
      checks++;
      if (done !== ed || busy !== eb)
        $display("FAIL basic_done_busy c%0d: got %b%b, need %b%b",
          c, done, busy, ed, eb);
      else passes++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (expq.size() != 0)
      $display("FAIL basic_drain: got %0d left, need 0", expq.size());
    else passes++;
  endtask

  task automatic test_backpressure;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int dones = 0;
    int rds = 0;
    int p0 = pops;
    start_xfer(16'h0040, 16'd6);
    for (int c = 1; c <= 40; c++) begin
      out_ready = pat[(c - 1) % 4];
      @(negedge clk);
      if (done) dones++;
      if (mem_rd_en) rds++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    checks++;
    if (dones != 1 || rds != 6)
      $display("FAIL bp_counts: got done=%0d rd=%0d, need 1/6",
        dones, rds);
    else passes++;
    checks++;
    if (pops - p0 != 6 || expq.size() != 0)
      $display("FAIL bp_delivered: got %0d left=%0d, need 6/0",
        pops - p0, expq.size());
    else passes++;
  endtask

  task automatic test_zero_length;
    bit ed;
    out_ready = 1'b1;
    start_xfer(16'h0080, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ed = (c == 1);
      checks++;
      if (done !== ed || busy !== 1'b0)
        $display("FAIL zero_done c%0d: got %b%b, need %b0",
          c, done, busy, ed);
      else passes++;
      checks++;
      if (mem_rd_en !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL zero_quiet c%0d: got %b%b, need 00",
          c, mem_rd_en, out_valid);
      else passes++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap;
    logic er;
    logic [15:0] ea;
    out_ready = 1'b1;
    start_xfer(16'hFFFE, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      er = (c <= 4);
      ea = 16'(16'hFFFE + c - 1);
      checks++;
      if (mem_rd_en !== er || (er && mem_addr !== ea))
        $display("FAIL wrap_rd c%0d: got %b/%h, need %b/%h",
          c, mem_rd_en, mem_addr, er, ea);
      else passes++;
      checks++;
      if (done !== (c == 7))
        $display("FAIL wrap_done c%0d: got %b, need %b",
          c, done, (c == 7));
      else passes++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (expq.size() != 0)
      $display("FAIL wrap_drain: got %0d left, need 0", expq.size());
    else passes++;
  endtask

  task automatic test_start_busy;
    int dones = 0;
    int rds = 0;
    int bad = 0;
    int p0 = pops;
    out_ready = 1'b1;
    start_xfer(16'h0200, 16'd5);
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        start = 1'b1;
        base_addr = 16'h0100;
        length = 16'd2;
      end
      if (c == 3) start = 1'b0;
      @(negedge clk);
      if (done) dones++;
      if (mem_rd_en) begin
        rds++;
        if (mem_addr < 16'h0200 || mem_addr > 16'h0204) bad++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones != 1 || rds != 5 || bad != 0)
      $display("FAIL busy_ignore: got d=%0d rd=%0d bad=%0d, need 1/5/0",
        dones, rds, bad);
    else passes++;
    checks++;
    if (pops - p0 != 5 || expq.size() != 0)
      $display("FAIL busy_words: got %0d left=%0d, need 5/0",
        pops - p0, expq.size());
    else passes++;
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int p0;
    out_ready = 1'b1;
    p0 = pops;
    start_xfer(16'h0300, 16'd8);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    checks++;
    if (pops - p0 != 2)
      $display("FAIL mid_popped: got %0d, need 2", pops - p0);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rd_en, out_valid} !== 4'b0 ||
        mem_addr !== 16'h0 || out_data !== 16'h0)
      $display("FAIL mid_reset_outputs: got b%b d%b r%b v%b a%h o%h, need 0",
        busy, done, mem_rd_en, out_valid, mem_addr, out_data);
    else passes++;
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones != 0)
      $display("FAIL mid_no_done: got %0d, need 0", dones);
    else passes++;
    p0 = pops;
    start_xfer(16'h0020, 16'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (mem_rd_en !== (c == 1) ||
          (c == 1 && mem_addr !== 16'h0020))
        $display("FAIL mid_restart_rd c%0d: got %b/%h, need %b/0020",
          c, mem_rd_en, mem_addr, (c == 1));
      else passes++;
      checks++;
      if (done !== (c == 4))
        $display("FAIL mid_restart_done c%0d: got %b, need %b",
          c, done, (c == 4));
      else passes++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (pops - p0 != 1 || expq.size() != 0)
      $display("FAIL mid_restart_words: got %0d left=%0d, need 1/0",
        pops - p0, expq.size());
    else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
